wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline's write-back stream (MEM/WB register outputs) and the long-latency multiply/divide unit (MDU). Pipeline writes always take the port. MDU results are held in a small result buffer and drained into free write-back slots. A starvation counter can request a pipeline bubble, and a write-after-write check discards stale buffered MDU results. The block sits between the MEM/WB register / MDU outputs and the register file.

## Interface
Parameters:
- `DEPTH`, 2: MDU result buffer entries; power of two, 2..4.
- `STARVE_MAX`, 8: number of waiting cycles before a bubble is requested; range 1..255.

Ports (reset is synchronous and active-high):
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pipe_wb_en`  in  1  pipeline write-back valid.
- `pipe_rd`  in  5  pipeline destination register.
- `pipe_data`  in  32  pipeline write data.
- `mdu_valid`  in  1  MDU result offered.
- `mdu_rd`  in  5  MDU destination register.
- `mdu_data`  in  32  MDU result.
- `mdu_ready`  out  1  buffer can accept an MDU result this cycle.
- `rf_w_en`  out  1  register-file write enable.
- `rf_w_addr`  out  5  register-file write address.
- `rf_w_data`  out  32  register-file write data.
- `pipe_stall`  out  1  request for a one-slot pipeline bubble.

## Operation
- Pipeline slot is busy when `pipe_wb_en`=1 and `pipe_rd`≠0. Otherwise the slot is free.
- Slot busy: `rf_w_*` is driven from `pipe_*`.
- Slot free and buffer non-empty: `rf_w_*` is driven from the buffer head, and the head is popped.
- Slot free and buffer empty: `rf_w_en`=0.
- The register-file write path is combinational: pipeline writes pass through with zero latency, and the buffer head is registered state.
- MDU handshake: a transfer occurs when `mdu_valid` and `mdu_ready` are both high. `mdu_ready` = not full.
- `mdu_ready` is not raised by a same-cycle pop when the buffer is full.
- The MDU holds `mdu_valid`, `mdu_rd` and `mdu_data` stable until the transfer.
- An MDU result with `mdu_rd`=0 is accepted and discarded.
- WAW kill: a busy pipeline slot is always younger than any MDU result. Therefore:
  - every buffered entry whose rd equals `pipe_rd` is invalidated that cycle;
  - an MDU result transferring that same cycle with an equal rd is accepted but not stored.
- Invalidated entries are skipped: the pop logic never presents an invalid head. Entries are compacted, or skipped at pop time at no extra write cost.
- Buffer order is FIFO over valid entries.
- Starvation counter (8 bits):
  - cleared on reset, on a pop, and whenever the buffer has no valid entries;
  - otherwise increments, saturating at `STARVE_MAX`.
- `pipe_stall` = registered (counter == `STARVE_MAX`).
- The arbiter does not override a busy pipeline slot while `pipe_stall` is high; inserting the bubble is the pipeline's job.

## Timing
- During and after reset, `rst` clears the buffer and counter. Outputs:
  - `mdu_ready`=0 while `rst`=1, and 1 from the first cycle after;
  - `rf_w_en`=0 while `rst`=1, regardless of `pipe_*`;
  - `rf_w_addr`=0, `rf_w_data`=0 when there is no write;
  - `pipe_stall`=0.
- Minimum MDU latency is 1 cycle: a result transferred in cycle N can be written in cycle N+1 at the earliest. There is no same-cycle bypass to the register file.
- `pipe_stall` asserts STARVE_MAX+1 cycles after the buffer first holds a valid entry with no free slot. It deasserts the cycle after a pop.
- Reset asserted mid-operation drops all buffered results with no write; the MDU is reset by the same `rst`.
- Simultaneous pop and push on a non-full buffer are both performed; occupancy is unchanged.

## Configuration
- `WB_ARB_STARVE_EN` defined: starvation counter and the `pipe_stall` logic are present, as specified above.
- `WB_ARB_STARVE_EN` undefined: no counter; `pipe_stall` is tied to 0. MDU results drain only in naturally free slots, and the MDU back-pressures through `mdu_ready`.

## Structure
- Shared package `riscv_pkg`:
  - `XLEN`=32 and `REG_AW`=5;
  - typedef `wb_req_t` {en, rd, data}, used for both the pipeline and buffer entries.
- One sub-module, `wb_result_fifo`: DEPTH-entry FIFO with per-entry valid bits and a kill-by-rd input. It exposes head, pop, push, full and has_valid.
- The top level holds the arbitration mux and the starvation counter.

## Test plan
- Reset check: drive `rst`=1 with `pipe_wb_en`=1, `pipe_rd`=5 → `rf_w_en`=0, `mdu_ready`=0, `pipe_stall`=0. Release reset → `mdu_ready`=1.
- Free-slot drain: MDU rd=7, data 0x1234 in cycle N; pipeline idle → cycle N+1: `rf_w_en`=1, addr 7, data 0x1234; buffer then empty.
- Priority and back-pressure, DEPTH=2: pipeline busy every cycle, MDU offers 3 results → the first two are accepted and `mdu_ready`=0 with `mdu_valid` held. Free slot → writes in FIFO order, then the third result is accepted.
- WAW kill: buffer holds rd=9 (0xAAAA), pipeline writes rd=9 (0xBBBB) → the register file receives only 0xBBBB; a later free slot produces no write.
- Starvation (macro defined, STARVE_MAX=8): one buffered entry with the pipeline continuously busy → `pipe_stall` rises in the 9th cycle. A free slot pops it and `pipe_stall` falls the next cycle. With the macro undefined → `pipe_stall` stays 0.
- x0 handling: `pipe_rd`=0 with `pipe_wb_en`=1 counts as a free slot and pops the head. An MDU result with rd=0 never produces a write.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file write definitions for the write-back arbiter.
// Contents:
//   XLEN      register width
//   REG_AW    register address width
//   wb_req_t  write request {en, rd, data}; used both for the pipeline
//             write-back stream and for the MDU result buffer entries.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic              en;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result buffer: DEPTH-entry FIFO with per-entry valid bits and a
// kill-by-rd port. Valid entries are kept compacted at the low indices,
// so the head is always entry 0 and never an invalidated result.
// Ports:
//   clk, rst      clock, synchronous active-high reset (clears all entries)
//   push_i        result to append when push_i.en=1 (rd=0 is discarded)
//   pop_i         remove the head this cycle
//   kill_en_i     invalidate every entry whose rd equals kill_rd_i
//   kill_rd_i     destination register being overwritten by the pipeline
//   head_o        oldest valid entry (en=0 when empty)
//   full_o        all DEPTH entries valid
//   has_valid_o   at least one valid entry
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  wb_req_t           push_i,
  input  logic              pop_i,
  input  logic              kill_en_i,
  input  logic [REG_AW-1:0] kill_rd_i,
  output wb_req_t           head_o,
  output logic              full_o,
  output logic              has_valid_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_req_t          ent_q [DEPTH];
  wb_req_t          ent_d [DEPTH];
  logic [CNT_W-1:0] fill;
  logic             store;

  // A result killed in the cycle it arrives is accepted but never stored.
  assign store = push_i.en && (push_i.rd != '0) &&
                 !(kill_en_i && (push_i.rd == kill_rd_i));

  // Keep surviving entries in order, packed from index 0, then append.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      ent_d[j] = '0;
    end
    fill = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].en && !(kill_en_i && (ent_q[i].rd == kill_rd_i)) &&
          !(pop_i && (i == 0))) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (CNT_W'(j) == fill) ent_d[j] = ent_q[i];
        end
        fill = fill + CNT_W'(1);
      end
    end
    if (store) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (CNT_W'(j) == fill) ent_d[j] = push_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  assign head_o      = ent_q[0];
  assign has_valid_o = ent_q[0].en;
  assign full_o      = ent_q[DEPTH-1].en;

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the pipeline
// write-back stream and buffered MDU results. Pipeline writes always win;
// buffered MDU results drain into free slots in FIFO order, and a pipeline
// write to the same rd kills older buffered results (write-after-write).
// Build option: define WB_ARB_STARVE_EN to add the starvation counter that
// raises pipe_stall; otherwise pipe_stall is tied low.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   pipe_wb_en, pipe_rd, pipe_data  pipeline write-back (MEM/WB)
//   mdu_valid, mdu_rd, mdu_data     MDU result offer
//   mdu_ready                       buffer can accept an MDU result
//   rf_w_en, rf_w_addr, rf_w_data   register-file write port (combinational)
//   pipe_stall                      request for a one-slot pipeline bubble
module wb_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_wb_en,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              mdu_valid,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [XLEN-1:0]   mdu_data,
  output logic              mdu_ready,
  output logic              rf_w_en,
  output logic [REG_AW-1:0] rf_w_addr,
  output logic [XLEN-1:0]   rf_w_data,
  output logic              pipe_stall
);

  localparam int unsigned STARVE_W = 8;

  if ((DEPTH != 2 && DEPTH != 4) || STARVE_MAX < 1 || STARVE_MAX > 255) begin : g_bad_param
    $error("wb_port_arbiter: DEPTH must be 2 or 4, STARVE_MAX 1..255");
  end

  wb_req_t push_req;
  wb_req_t head;
  logic    busy;
  logic    full;
  logic    has_valid;
  logic    pop;

  // rd=0 writes are architecturally void, so such a slot is free.
  assign busy      = pipe_wb_en && (pipe_rd != '0);
  assign mdu_ready = !rst && !full;
  assign pop       = !rst && !busy && has_valid;
  assign push_req  = '{en: mdu_valid && mdu_ready, rd: mdu_rd, data: mdu_data};

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_req),
    .pop_i       (pop),
    .kill_en_i   (busy),
    .kill_rd_i   (pipe_rd),
    .head_o      (head),
    .full_o      (full),
    .has_valid_o (has_valid)
  );

  // Write-port mux: pipeline first, then the buffer head.
  always_comb begin
    rf_w_en   = 1'b0;
    rf_w_addr = '0;
    rf_w_data = '0;
    if (!rst) begin
      if (busy) begin
        rf_w_en   = 1'b1;
        rf_w_addr = pipe_rd;
        rf_w_data = pipe_data;
      end else if (head.en) begin
        rf_w_en   = 1'b1;
        rf_w_addr = head.rd;
        rf_w_data = head.data;
      end
    end
  end

`ifdef WB_ARB_STARVE_EN
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;
  logic                stall_q;

  // Counts cycles a valid result waits without a free slot.
  always_comb begin
    starve_d = starve_q;
    if (pop || !has_valid) begin
      starve_d = '0;
    end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= (starve_d == STARVE_W'(STARVE_MAX));
    end
  end

  // Masked during reset so a stale request never leaks into the reset cycle.
  assign pipe_stall = stall_q && !rst;
`else
  assign pipe_stall = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import riscv_pkg::*;

  localparam int unsigned DEPTH      = 2;
  localparam int unsigned STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst, pipe_wb_en, mdu_valid;
  logic [4:0]  pipe_rd, mdu_rd;
  logic [31:0] pipe_data, mdu_data;
  logic        mdu_ready, rf_w_en, pipe_stall;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .pipe_wb_en(pipe_wb_en), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_ready(mdu_ready),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .pipe_stall(pipe_stall)
  );

  // Reference model: queue of results still waiting, oldest first.
  typedef struct { logic [4:0] rd; logic [31:0] data; } ent_t;
  ent_t q[$];
  int unsigned run;  // consecutive cycles a result waited with no pop

  // MDU-side offer, held until it transfers.
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  // Outputs captured in the last cycle, for literal checks.
  logic        a_en, a_ready, a_stall;
  logic [4:0]  a_addr;
  logic [31:0] a_data;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic offer(input logic [4:0] rd, input logic [31:0] data);
    m_valid = 1'b1;
    m_rd    = rd;
    m_data  = data;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic cycle(input logic r, input logic pe, input logic [4:0] prd, input logic [31:0] pd);
    logic        busy, pop, xfer, e_en, e_ready, e_stall;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    ent_t        ne;
    rst = r; pipe_wb_en = pe; pipe_rd = prd; pipe_data = pd;
    mdu_valid = m_valid; mdu_rd = m_rd; mdu_data = m_data;
    #2;
    busy    = pe && (prd != 5'd0);
    pop     = 1'b0;
    e_en    = 1'b0; e_addr = 5'd0; e_data = 32'd0;
    e_ready = !r && (q.size() < DEPTH);
    e_stall = 1'b0;
`ifdef WB_ARB_STARVE_EN
    e_stall = !r && (run >= STARVE_MAX);
`endif
    if (!r) begin
      if (busy) begin
        e_en = 1'b1; e_addr = prd; e_data = pd;
      end else if (q.size() != 0) begin
        e_en = 1'b1; e_addr = q[0].rd; e_data = q[0].data; pop = 1'b1;
      end
    end
    a_en = rf_w_en; a_addr = rf_w_addr; a_data = rf_w_data;
    a_ready = mdu_ready; a_stall = pipe_stall;
    chk("rf_w_en",    32'(a_en),    32'(e_en));
    chk("rf_w_addr",  32'(a_addr),  32'(e_addr));
    chk("rf_w_data",  a_data,       e_data);
    chk("mdu_ready",  32'(a_ready), 32'(e_ready));
    chk("pipe_stall", 32'(a_stall), 32'(e_stall));
    xfer = m_valid && e_ready;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      run = 0;
      m_valid = 1'b0;
    end else begin
      if (q.size() != 0 && !pop) begin
        if (run < STARVE_MAX) run++;
      end else begin
        run = 0;
      end
      if (busy) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].rd == prd) q.delete(i);
        end
      end
      if (pop) void'(q.pop_front());
      if (xfer) begin
        if (m_rd != 5'd0 && !(busy && m_rd == prd)) begin
          ne.rd = m_rd; ne.data = m_data;
          q.push_back(ne);
        end
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  logic        r_r, r_pe, want_stall;
  logic [4:0]  r_prd;
  logic [31:0] r_pd;

  initial begin
    m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0; run = 0;
    rst = 1'b1; pipe_wb_en = 1'b0; pipe_rd = 5'd0; pipe_data = 32'd0;
    mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_data = 32'd0;
    @(negedge clk);

    // Reset with a pipeline write present: nothing gets through.
    cycle(1'b1, 1'b1, 5'd5, 32'h5555);
    cycle(1'b1, 1'b1, 5'd5, 32'h5555);
    chk("rst_wen", 32'(a_en), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("post_rst_ready", 32'(a_ready), 32'd1);

    // Free-slot drain, one-cycle minimum latency.
    offer(5'd7, 32'h1234);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("no_bypass", 32'(a_en), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("drain_en", 32'(a_en), 32'd1);
    chk("drain_addr", 32'(a_addr), 32'd7);
    chk("drain_data", a_data, 32'h1234);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("drain_empty", 32'(a_en), 32'd0);

    // Back-pressure with a busy pipeline, then FIFO-order drain.
    offer(5'd10, 32'hA1);
    cycle(1'b0, 1'b1, 5'd1, 32'h1111);
    offer(5'd11, 32'hA2);
    cycle(1'b0, 1'b1, 5'd1, 32'h1112);
    offer(5'd12, 32'hA3);
    cycle(1'b0, 1'b1, 5'd1, 32'h1113);
    chk("bp_ready", 32'(a_ready), 32'd0);
    chk("bp_pipe_data", a_data, 32'h1113);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("bp_first", a_data, 32'hA1);
    chk("bp_no_same_cycle_ready", 32'(a_ready), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("bp_second", a_data, 32'hA2);
    chk("bp_ready_again", 32'(a_ready), 32'd1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("bp_third_addr", 32'(a_addr), 32'd12);
    chk("bp_third", a_data, 32'hA3);

    // WAW kill of a buffered entry, then of a same-cycle arrival.
    offer(5'd9, 32'hAAAA);
    cycle(1'b0, 1'b1, 5'd1, 32'h0);
    cycle(1'b0, 1'b1, 5'd9, 32'hBBBB);
    chk("waw_pipe", a_data, 32'hBBBB);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("waw_killed", 32'(a_en), 32'd0);
    offer(5'd9, 32'hCCCC);
    cycle(1'b0, 1'b1, 5'd9, 32'hDDDD);
    chk("waw_same_cycle", a_data, 32'hDDDD);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("waw_same_cycle_killed", 32'(a_en), 32'd0);

    // x0: pipeline rd=0 is a free slot; an MDU rd=0 result is dropped.
    offer(5'd3, 32'h3333);
    cycle(1'b0, 1'b1, 5'd1, 32'h0);
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF);
    chk("x0_pipe_pops", a_data, 32'h3333);
    offer(5'd0, 32'hDEAD);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("x0_mdu_nowrite", 32'(a_en), 32'd0);

    // Starvation: one entry waits behind a continuously busy pipeline.
    offer(5'd4, 32'h4444);
    cycle(1'b0, 1'b1, 5'd1, 32'h0);
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b1, 5'd2, 32'(k));
      want_stall = 1'b0;
`ifdef WB_ARB_STARVE_EN
      want_stall = (k >= 9);
`endif
      chk("starve_stall", 32'(a_stall), 32'(want_stall));
    end
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("starve_pop", a_data, 32'h4444);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("starve_release", 32'(a_stall), 32'd0);

    // Reset mid-operation drops buffered results.
    offer(5'd6, 32'h66);
    cycle(1'b0, 1'b1, 5'd1, 32'h0);
    cycle(1'b1, 1'b0, 5'd0, 32'd0);
    chk("midrst_wen", 32'(a_en), 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0);
    chk("midrst_dropped", 32'(a_en), 32'd0);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      r_r = ($urandom_range(0, 199) == 0);
      if (!m_valid && $urandom_range(0, 99) < 40) begin
        m_valid = 1'b1;
        m_rd    = 5'($urandom_range(0, 5));
        if ($urandom_range(0, 3) == 0) m_rd = 5'($urandom());
        m_data  = $urandom();
      end
      r_pe  = ($urandom_range(0, 99) < 55);
      r_prd = 5'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) r_prd = 5'($urandom());
      r_pd  = $urandom();
      cycle(r_r, r_pe, r_prd, r_pd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
